// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between the writeback requesters (master) and the regfile write arbiter (slave).
interface regfile_write_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic                          clear_start;
  logic                          clear_busy;
  logic                          clear_done;
  logic                          ctrl_writeEnable;
  logic [ADDR_WIDTH-1:0]         ctrl_writeReg;
  logic [DATA_WIDTH-1:0]         data_writeReg;

  modport master (
    output req_valid, req_addr, req_data, clear_start,
    input  req_ready, clear_busy, clear_done,
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg
  );

  modport slave (
    input  req_valid, req_addr, req_data, clear_start,
    output req_ready, clear_busy, clear_done,
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin share of the regfile write port plus a zero-clear sequencer for registers 1..31.
// Latency: grant -> registered write 1 cycle; req_ready is combinational and withheld while clearing.
module regfile_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                   clock,
  input  logic                   ctrl_reset_n,
  regfile_write_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [ADDR_WIDTH-1:0] LAST_REG = '1;

  typedef enum logic {ARB, CLEAR} state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;

  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   wreg_q, wreg_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic [PTR_W:0]          scan;
  logic                    grant_any;
  logic [PTR_W-1:0]        grant_idx;
  logic [NUM_REQ-1:0]      ready;
  logic                    xfer;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_data;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      if (scan >= (PTR_W+1)'(NUM_REQ)) begin
        scan = scan - (PTR_W+1)'(NUM_REQ);
      end
      if (!grant_any && bus.req_valid[scan[PTR_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = scan[PTR_W-1:0];
      end
    end
  end

  assign sel_addr = bus.req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_data = bus.req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q   <= ARB;
      rr_ptr_q  <= '0;
      clr_cnt_q <= '0;
      we_q      <= 1'b0;
      wreg_q    <= '0;
      wdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      clr_cnt_q <= clr_cnt_d;
      we_q      <= we_d;
      wreg_q    <= wreg_d;
      wdata_q   <= wdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ARB: begin
        if (bus.clear_start) begin
          // Register 1 is issued on this edge, so the counter starts at 2.
          state_d   = CLEAR;
          clr_cnt_d = ADDR_WIDTH'(2);
        end else if (xfer) begin
          rr_ptr_d = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
        end
      end
      CLEAR: begin
        if (clr_cnt_q == LAST_REG) begin
          state_d   = ARB;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_comb begin
    ready   = '0;
    xfer    = 1'b0;
    we_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ARB: begin
        if (bus.clear_start) begin
          we_d    = 1'b1;
          wreg_d  = ADDR_WIDTH'(1);
          wdata_d = '0;
          busy_d  = 1'b1;
        end else if (grant_any && ctrl_reset_n) begin
          ready = NUM_REQ'(1) << grant_idx;
          xfer  = 1'b1;
          // Writes to register 0 complete the handshake but never reach the regfile.
          if (sel_addr != '0) begin
            we_d    = 1'b1;
            wreg_d  = sel_addr;
            wdata_d = sel_data;
          end
        end
      end
      CLEAR: begin
        we_d    = 1'b1;
        wreg_d  = clr_cnt_q;
        wdata_d = '0;
        busy_d  = 1'b1;
        done_d  = (clr_cnt_q == LAST_REG);
      end
      default: ;
    endcase
  end

  assign bus.req_ready        = ready;
  assign bus.ctrl_writeEnable = we_q;
  assign bus.ctrl_writeReg    = wreg_q;
  assign bus.data_writeReg    = wdata_q;
  assign bus.clear_busy       = busy_q;
  assign bus.clear_done       = done_q;

  a_ready_onehot0: assert property (@(posedge clock) disable iff (!ctrl_reset_n)
    $onehot0(bus.req_ready));
  a_ready_needs_valid: assert property (@(posedge clock) disable iff (!ctrl_reset_n)
    (bus.req_ready & ~bus.req_valid) == '0);
  a_no_grant_in_clear: assert property (@(posedge clock) disable iff (!ctrl_reset_n)
    (state_q == CLEAR) |-> (bus.req_ready == '0));
endmodule
